gs_ddram: RTL and testbench

GS_DDRAM -- requirements
Module: gs_ddram

---
 rtl/gs_ddram_pkg.sv | 13 +
 rtl/gs_ddram.sv | 115 +++++++++++
 tb/tb_gs_ddram.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/gs_ddram_pkg.sv
// Shared definitions for the GS DDRAM byte-port bridge: controller states and default region base.
package gs_ddram_pkg;

    localparam logic [28:0] GS_DDRAM_BASE = 29'h0600_0000;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        READ_REQ,
        READ_DATA
    } state_t;

endpackage

// File: rtl/gs_ddram.sv
// Byte-wide CPU port onto a 64-bit DDR controller with a single write-through line cache.
module gs_ddram
    import gs_ddram_pkg::*;
#(
    parameter logic [28:0] BASE = GS_DDRAM_BASE
) (
    input  logic        DDRAM_CLK,
    input  logic        reset,
    input  logic        DDRAM_BUSY,
    output logic [7:0]  DDRAM_BURSTCNT,
    output logic [28:0] DDRAM_ADDR,
    input  logic [63:0] DDRAM_DOUT,
    input  logic        DDRAM_DOUT_READY,
    output logic        DDRAM_RD,
    output logic [63:0] DDRAM_DIN,
    output logic [7:0]  DDRAM_BE,
    output logic        DDRAM_WE,
    input  logic [20:0] addr,
    input  logic [7:0]  din,
    output logic [7:0]  dout,
    input  logic        we,
    input  logic        rd,
    output logic        ready
);

    state_t      state;
    logic [17:0] tag;
    logic        valid;
    logic [63:0] data;
    logic [17:0] req_line;

    logic        prev_act;
    logic        prev_we;
    logic [20:0] prev_addr;

    logic        act;
    logic        new_req;
    logic        hit;
    logic        acc_wr;
    logic        acc_miss;

    // A strobe held across a transaction is not a new request once back in IDLE.
    assign act      = rd | we;
    assign new_req  = act && (!prev_act || ({addr, we} != {prev_addr, prev_we}));
    assign hit      = valid && (tag == addr[20:3]);
    assign acc_wr   = (state == IDLE) && new_req && we;
    assign acc_miss = (state == IDLE) && new_req && !we && !hit;
    assign ready    = (state == IDLE) && !acc_wr && !acc_miss;

    assign dout           = data[{addr[2:0], 3'b000} +: 8];
    assign DDRAM_BURSTCNT = 8'd1;

    always_ff @(posedge DDRAM_CLK or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            tag        <= '0;
            valid      <= 1'b0;
            data       <= '0;
            req_line   <= '0;
            prev_act   <= 1'b0;
            prev_we    <= 1'b0;
            prev_addr  <= '0;
            DDRAM_ADDR <= BASE;
            DDRAM_DIN  <= '0;
            DDRAM_BE   <= '0;
            DDRAM_WE   <= 1'b0;
            DDRAM_RD   <= 1'b0;
        end else begin
            prev_act  <= act;
            prev_we   <= we;
            prev_addr <= addr;
            case (state)
                IDLE: begin
                    if (acc_wr) begin
                        DDRAM_ADDR <= BASE + {11'b0, addr[20:3]};
                        DDRAM_DIN  <= {8{din}};
                        DDRAM_BE   <= 8'h01 << addr[2:0];
                        DDRAM_WE   <= 1'b1;
                        state      <= WRITE;
                        if (hit) begin
                            data[{addr[2:0], 3'b000} +: 8] <= din;
                        end
                    end else if (acc_miss) begin
                        DDRAM_ADDR <= BASE + {11'b0, addr[20:3]};
                        req_line   <= addr[20:3];
                        DDRAM_RD   <= 1'b1;
                        state      <= READ_REQ;
                    end
                end
                WRITE: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_WE <= 1'b0;
                        state    <= IDLE;
                    end
                end
                READ_REQ: begin
                    if (!DDRAM_BUSY) begin
                        DDRAM_RD <= 1'b0;
                        state    <= READ_DATA;
                    end
                end
                READ_DATA: begin
                    if (DDRAM_DOUT_READY) begin
                        data  <= DDRAM_DOUT;
                        tag   <= req_line;
                        valid <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gs_ddram.sv
// Scoreboard bench for gs_ddram: byte-level memory reference model plus a behavioural DDR responder.
module tb_gs_ddram;

    localparam logic [28:0] BASE = 29'h0600_0000;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [7:0]  burstcnt;
    logic [28:0] ddr_addr;
    logic [63:0] ddr_dout;
    logic        ddr_dout_ready;
    logic        ddr_rd;
    logic [63:0] ddr_din;
    logic [7:0]  ddr_be;
    logic        ddr_we;
    logic [20:0] addr;
    logic [7:0]  din;
    logic [7:0]  dout;
    logic        we;
    logic        rd;
    logic        ready;

    gs_ddram #(.BASE(BASE)) dut (
        .DDRAM_CLK        (clk),
        .reset            (rst),
        .DDRAM_BUSY       (busy),
        .DDRAM_BURSTCNT   (burstcnt),
        .DDRAM_ADDR       (ddr_addr),
        .DDRAM_DOUT       (ddr_dout),
        .DDRAM_DOUT_READY (ddr_dout_ready),
        .DDRAM_RD         (ddr_rd),
        .DDRAM_DIN        (ddr_din),
        .DDRAM_BE         (ddr_be),
        .DDRAM_WE         (ddr_we),
        .addr             (addr),
        .din              (din),
        .dout             (dout),
        .we               (we),
        .rd               (rd),
        .ready            (ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit          wr;
        logic [28:0] addr;
        logic [7:0]  be;
        logic [63:0] din;
    } ddr_op_t;

    ddr_op_t     exp_ddr[$];
    logic [7:0]  exp_rd[$];
    logic [63:0] ddr_mem[logic [28:0]];
    logic [63:0] ref_words[logic [17:0]];

    int total = 0;
    int bad = 0;
    bit rd_active = 0;
    bit rand_busy = 0;
    int busy_cnt = 0;
    int rdy_delay = 0;
    int pend_cnt = 0;
    logic [28:0] pend_addr;
    int rd_hi_cnt = 0;
    int we_hi_cnt = 0;

    // Reference model: which line, if any, the one-line cache currently holds.
    bit          m_valid = 0;
    logic [17:0] m_line = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] init_word(input logic [17:0] l);
        logic [31:0] h;
        h = {14'b0, l} * 32'h9E37_79B1;
        return {h, ~h ^ 32'h5A5A_1234};
    endfunction

    function automatic logic [63:0] ddr_word(input logic [28:0] a);
        logic [28:0] off;
        off = a - BASE;
        return ddr_mem.exists(a) ? ddr_mem[a] : init_word(off[17:0]);
    endfunction

    function automatic logic [63:0] ref_word(input logic [17:0] l);
        return ref_words.exists(l) ? ref_words[l] : init_word(l);
    endfunction

    task automatic preload(input logic [17:0] l, input logic [63:0] w);
        ddr_mem[BASE + {11'b0, l}] = w;
        ref_words[l] = w;
    endtask

    // DDR responder: wait-request generation and delayed read replies.
    initial begin
        busy = 1'b0;
        ddr_dout = '0;
        ddr_dout_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (busy_cnt > 0) begin
                busy = 1'b1;
                busy_cnt--;
            end else begin
                busy = rand_busy ? ($urandom_range(0, 2) == 0) : 1'b0;
            end
            ddr_dout_ready = 1'b0;
            if (pend_cnt > 0) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    ddr_dout = ddr_word(pend_addr);
                    ddr_dout_ready = 1'b1;
                end
            end else if (rand_busy && $urandom_range(0, 7) == 0) begin
                ddr_dout = {$urandom, $urandom};
                ddr_dout_ready = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (ddr_rd) rd_hi_cnt++;
        if (ddr_we) we_hi_cnt++;
        if (!rst && ddr_we && !busy) begin
            logic [63:0] w;
            w = ddr_word(ddr_addr);
            for (int unsigned i = 0; i < 8; i++)
                if (ddr_be[i]) w[i*8 +: 8] = ddr_din[i*8 +: 8];
            ddr_mem[ddr_addr] = w;
        end
        if (!rst && ddr_rd && !busy) begin
            pend_addr = ddr_addr;
            pend_cnt = (rdy_delay != 0) ? rdy_delay : $urandom_range(1, 3);
        end
    end

    // Monitor: DDR handshakes and completed CPU reads are checked against queued expectations.
    always @(negedge clk) begin
        if (!rst && (ddr_we || ddr_rd) && !busy) begin
            if (exp_ddr.size() == 0) begin
                chk("ddr_unexpected_access", {ddr_we, ddr_rd, ddr_addr}, '0);
            end else begin
                ddr_op_t e;
                e = exp_ddr.pop_front();
                chk("ddr_is_write", ddr_we, e.wr);
                chk("ddr_rd_we_exclusive", ddr_rd & ddr_we, 0);
                chk("ddr_addr", ddr_addr, e.addr);
                chk("ddr_burstcnt", burstcnt, 8'd1);
                if (e.wr) begin
                    chk("ddr_be", ddr_be, e.be);
                    chk("ddr_din", ddr_din, e.din);
                end
            end
        end
        if (rd_active && rd && ready) begin
            if (exp_rd.size() == 0) chk("rd_unexpected", dout, '0);
            else chk("rd_dout", dout, exp_rd.pop_front());
        end
    end

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (!ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            total++;
            bad++;
            $display("FAIL %s_timeout actual=ready_low required=ready_high", name);
        end
    endtask

    task automatic do_write(input logic [20:0] a, input logic [7:0] d, input bit both);
        ddr_op_t e;
        logic [63:0] w;
        @(posedge clk);
        #1;
        addr = a; din = d; we = 1'b1; rd = both;
        e.wr = 1; e.addr = BASE + {11'b0, a[20:3]};
        e.be = 8'h01 << a[2:0]; e.din = {8{d}};
        exp_ddr.push_back(e);
        w = ref_word(a[20:3]);
        w[a[2:0]*8 +: 8] = d;
        ref_words[a[20:3]] = w;
        @(negedge clk);
        chk("wr_ready_low", ready, 0);
        wait_ready("wr");
        @(posedge clk);
        #1;
        we = 1'b0; rd = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic do_read(input logic [20:0] a, input int bc);
        bit hit;
        ddr_op_t e;
        logic [63:0] w;
        hit = m_valid && (m_line == a[20:3]);
        @(posedge clk);
        #1;
        addr = a; rd = 1'b1; we = 1'b0;
        busy_cnt = bc;
        if (!hit) begin
            e.wr = 0; e.addr = BASE + {11'b0, a[20:3]}; e.be = '0; e.din = '0;
            exp_ddr.push_back(e);
            m_valid = 1;
            m_line = a[20:3];
        end
        w = ref_word(a[20:3]);
        exp_rd.push_back(w[a[2:0]*8 +: 8]);
        rd_active = 1;
        @(negedge clk);
        if (hit) chk("rd_hit_ready_high", ready, 1);
        else chk("rd_miss_ready_low", ready, 0);
        wait_ready("rd");
        @(posedge clk);
        #1;
        rd = 1'b0; rd_active = 0;
        @(posedge clk);
        #1;
    endtask

    logic [17:0] pool [4];

    initial begin
        rst = 1'b1; addr = '0; din = '0; we = 1'b0; rd = 1'b0;
        pool[0] = 18'h0; pool[1] = 18'h1; pool[2] = 18'h12345; pool[3] = 18'h3FFFF;
        #12;
        chk("reset_ready", ready, 1);
        chk("reset_rd", ddr_rd, 0);
        chk("reset_we", ddr_we, 0);
        chk("reset_addr", ddr_addr, BASE);
        chk("reset_be", ddr_be, 0);
        chk("reset_din", ddr_din, 0);
        chk("reset_dout", dout, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single write, no wait-request.
        we_hi_cnt = 0;
        do_write(21'h00005, 8'hA5, 0);
        chk("wr_we_cycles", we_hi_cnt, 1);

        // Read miss with three wait-request cycles and a reply two cycles later.
        preload(18'h1, 64'h8877_6655_4433_2211);
        rdy_delay = 2;
        rd_hi_cnt = 0;
        do_read(21'h00008, 4);
        chk("miss_rd_cycles", rd_hi_cnt, 4);
        chk("miss_dout", dout, 8'h11);
        rdy_delay = 0;

        do_read(21'h0000F, 0);
        chk("hit_dout_top_byte", dout, 8'h88);

        do_write(21'h0000A, 8'h5A, 0);
        do_read(21'h0000A, 0);
        chk("write_through_dout", dout, 8'h5A);

        do_write(21'h1FFFFF, 8'h3C, 1);

        // Reset while waiting for read data; the late reply must be ignored.
        rdy_delay = 4;
        @(posedge clk);
        #1;
        begin
            ddr_op_t e;
            int n;
            addr = 21'h00100; rd = 1'b1;
            e.wr = 0; e.addr = BASE + 29'h20; e.be = '0; e.din = '0;
            exp_ddr.push_back(e);
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (!(ddr_rd && !busy) && n < 50);
            if (n >= 50) begin
                total++;
                bad++;
                $display("FAIL rst_read_handshake_timeout actual=no_handshake required=handshake");
            end
        end
        @(posedge clk);
        #3;
        rst = 1'b1; rd = 1'b0;
        #1;
        chk("midrst_rd", ddr_rd, 0);
        chk("midrst_ready", ready, 1);
        chk("midrst_addr", ddr_addr, BASE);
        chk("midrst_be", ddr_be, 0);
        m_valid = 0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("midrst_pulse_ignored_dout", dout, 0);
        rdy_delay = 0;
        do_read(21'h00100, 0);

        // Randomized traffic over a few lines so hits, misses and write hits all occur.
        rand_busy = 1;
        for (int unsigned k = 0; k < 300; k++) begin
            logic [20:0] a;
            int unsigned op;
            a = {pool[$urandom_range(0, 3)], 3'($urandom_range(0, 7))};
            op = $urandom_range(0, 9);
            if (op < 4) do_read(a, 0);
            else do_write(a, 8'($urandom), op >= 8);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_busy = 0;
        repeat (5) @(posedge clk);
        chk("ddr_queue_empty", exp_ddr.size(), 0);
        chk("rd_queue_empty", exp_rd.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
